// File: rtl/timer_cfg_pkg.sv
// Shared types and register map for the interval-timer configuration master.
package timer_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE, W_STOP, W_PL, W_PH, W_CLR, W_CTRL, RUN,
        ABORT, T_CLR, S_W, S_RL, S_RH, S_CAP, P_RD, P_WT
    } state_e;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;
    localparam int STAT_TO    = 0;

    localparam logic [15:0] CTRL_STOP_WORD = 16'h0001 << CTRL_STOP;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [2:0]  addr;
        logic [15:0] data;
    } avm_req_t;

    function automatic avm_req_t avm_wr(input logic [2:0] addr, input logic [15:0] data);
        return '{valid: 1'b1, write: 1'b1, addr: addr, data: data};
    endfunction

    function automatic avm_req_t avm_rd(input logic [2:0] addr);
        return '{valid: 1'b1, write: 1'b0, addr: addr, data: 16'h0000};
    endfunction

endpackage

// File: rtl/avm_single_access.sv
// Registers one Avalon-MM access per clock and flags the cycle in which read data is valid.
module avm_single_access (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_address,
    input  logic [15:0] req_writedata,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    output logic        rd_valid,
    output logic [2:0]  rd_address,
    output logic [15:0] rd_data
);

    logic rd_pending;

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 3'd0;
            avm_writedata  <= 16'h0000;
            rd_pending     <= 1'b0;
            rd_address     <= 3'd0;
        end else begin
            avm_chipselect <= req_valid;
            avm_write_n    <= !(req_valid && req_write);
            avm_address    <= req_valid ? req_address : 3'd0;
            avm_writedata  <= (req_valid && req_write) ? req_writedata : 16'h0000;
            rd_pending     <= avm_chipselect && avm_write_n;
            rd_address     <= avm_address;
        end
    end

    // The slave registers its read data, so it is valid the cycle after the access.
    assign rd_valid = rd_pending;
    assign rd_data  = avm_readdata;

endmodule

// File: rtl/timer_cfg_master.sv
// Command-driven Avalon-MM initiator that programs, runs, stops and snapshots an interval timer.
// Define TIMER_CFG_MASTER_POLL_EN to poll the status register instead of using irq.
module timer_cfg_master
    import timer_cfg_pkg::*;
#(
    parameter int TICK_CNT_W    = 16,
    parameter int POLL_INTERVAL = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_load,
    input  logic                  cmd_continuous,
    input  logic                  stop_req,
    input  logic                  snap_req,
    output logic [31:0]           snap_value,
    output logic                  snap_valid,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic                  running,
    output logic                  cmd_err,
    output logic [2:0]            avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic [15:0]           avm_writedata,
    input  logic [15:0]           avm_readdata,
    input  logic                  irq
);

`ifdef TIMER_CFG_MASTER_POLL_EN
    localparam bit POLL_EN = 1'b1;
`else
    localparam bit POLL_EN = 1'b0;
`endif

    localparam int POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL - 1);

    state_e      state, next_state;
    avm_req_t    req;
    logic [31:0] load_q;
    logic        cont_q;
    logic        irq_q;
    logic        stop_pend, to_pend, snap_pend;
    logic        stop_any, to_any, snap_any;
    logic        irq_rise, poll_hit, poll_due, accept;
    logic [POLL_W-1:0] poll_cnt;
    logic [15:0] snap_lo;
    logic [15:0] ctrl_word;
    logic        rd_valid;
    logic [2:0]  rd_address;
    logic [15:0] rd_data;

    assign cmd_ready = (state == IDLE);
    assign irq_rise  = !POLL_EN && irq && !irq_q;
    assign poll_hit  = POLL_EN && (state == P_WT) && rd_valid && rd_data[STAT_TO];
    assign poll_due  = POLL_EN && (poll_cnt == POLL_LAST);
    assign stop_any  = stop_req || stop_pend;
    assign to_any    = irq_rise || poll_hit || to_pend;
    assign snap_any  = snap_req || snap_pend;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        next_state = state;
        accept     = 1'b0;
        req        = '0;
        ctrl_word  = 16'h0000;
        ctrl_word[CTRL_START] = 1'b1;
        ctrl_word[CTRL_CONT]  = cont_q;
        ctrl_word[CTRL_ITO]   = !POLL_EN;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_load != 32'd0) next_state = W_STOP;
                end
            end
            W_STOP: next_state = W_PL;
            W_PL:   next_state = W_PH;
            W_PH:   next_state = W_CLR;
            W_CLR:  next_state = W_CTRL;
            W_CTRL: next_state = RUN;
            RUN: begin
                if (stop_any)      next_state = ABORT;
                else if (to_any)   next_state = T_CLR;
                else if (snap_any) next_state = S_W;
                else if (poll_due) next_state = P_RD;
            end
            ABORT:  next_state = IDLE;
            T_CLR:  next_state = cont_q ? RUN : IDLE;
            S_W:    next_state = S_RL;
            S_RL:   next_state = S_RH;
            S_RH:   next_state = S_CAP;
            S_CAP:  next_state = RUN;
            P_RD:   next_state = P_WT;
            P_WT:   next_state = RUN;
            default: next_state = IDLE;
        endcase

        // The access belonging to a state is issued on entry so it is on the bus during that state.
        case (next_state)
            W_STOP, ABORT: req = avm_wr(REG_CONTROL, CTRL_STOP_WORD);
            W_PL:          req = avm_wr(REG_PERIODL, load_q[15:0]);
            W_PH:          req = avm_wr(REG_PERIODH, load_q[31:16]);
            W_CLR, T_CLR:  req = avm_wr(REG_STATUS, 16'h0000);
            W_CTRL:        req = avm_wr(REG_CONTROL, ctrl_word);
            S_W:           req = avm_wr(REG_SNAPL, 16'h0000);
            S_RL:          req = avm_rd(REG_SNAPL);
            S_RH:          req = avm_rd(REG_SNAPH);
            P_RD:          req = avm_rd(REG_STATUS);
            default:       req = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            load_q     <= 32'd0;
            cont_q     <= 1'b0;
            irq_q      <= 1'b0;
            stop_pend  <= 1'b0;
            to_pend    <= 1'b0;
            snap_pend  <= 1'b0;
            running    <= 1'b0;
            tick       <= 1'b0;
            tick_count <= '0;
            cmd_err    <= 1'b0;
            snap_lo    <= 16'h0000;
            snap_value <= 32'd0;
            snap_valid <= 1'b0;
            poll_cnt   <= '0;
        end else begin
            state      <= next_state;
            irq_q      <= irq;
            tick       <= (state == T_CLR);
            cmd_err    <= accept && (cmd_load == 32'd0);
            snap_valid <= 1'b0;

            if (accept) begin
                load_q     <= cmd_load;
                cont_q     <= cmd_continuous;
                tick_count <= '0;
            end else if (state == T_CLR) begin
                tick_count <= tick_count + 1'b1;
            end

            if (state == W_CTRL)
                running <= 1'b1;
            else if (next_state == IDLE || next_state == ABORT)
                running <= 1'b0;

            // Events during a sequence stay pending; the one RUN dispatches is dropped.
            if (next_state == IDLE) begin
                stop_pend <= 1'b0;
                to_pend   <= 1'b0;
                snap_pend <= 1'b0;
            end else if (state != IDLE) begin
                stop_pend <= stop_any && (next_state != ABORT);
                to_pend   <= to_any && (next_state != T_CLR);
                snap_pend <= snap_any && (next_state != S_W);
            end

            if (rd_valid && rd_address == REG_SNAPL)
                snap_lo <= rd_data;
            if (rd_valid && rd_address == REG_SNAPH) begin
                snap_value <= {rd_data, snap_lo};
                snap_valid <= 1'b1;
            end

            if (state != RUN)
                poll_cnt <= '0;
            else if (poll_cnt != POLL_LAST)
                poll_cnt <= poll_cnt + 1'b1;
        end
    end

    avm_single_access u_access (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req.valid),
        .req_write      (req.write),
        .req_address    (req.addr),
        .req_writedata  (req.data),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .rd_valid       (rd_valid),
        .rd_address     (rd_address),
        .rd_data        (rd_data)
    );

endmodule

// File: tb/tb_timer_cfg_master.sv
// Directed testbench for timer_cfg_master with a behavioural interval-timer slave.
module tb_timer_cfg_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_load = 32'd0;
    logic        cmd_continuous = 1'b0;
    logic        stop_req = 1'b0;
    logic        snap_req = 1'b0;
    logic [31:0] snap_value;
    logic        snap_valid;
    logic        tick;
    logic [15:0] tick_count;
    logic        running;
    logic        cmd_err;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata;
    logic        irq;
    logic        use_model_irq = 1'b1;
    logic        irq_man = 1'b0;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timer_cfg_master #(.TICK_CNT_W(16), .POLL_INTERVAL(64)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_load       (cmd_load),
        .cmd_continuous (cmd_continuous),
        .stop_req       (stop_req),
        .snap_req       (snap_req),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid),
        .tick           (tick),
        .tick_count     (tick_count),
        .running        (running),
        .cmd_err        (cmd_err),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .irq            (irq)
    );

    // Interval-timer slave model: counts period..0, sets TO on reaching 0 and reloads.
    logic [15:0] m_per_l, m_per_h, m_snap_l, m_snap_h, m_rdata;
    logic [31:0] m_cnt;
    logic        m_run, m_to, m_ito, m_cont;

    assign avm_readdata = m_rdata;
    assign irq = use_model_irq ? (m_to & m_ito) : irq_man;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_per_l <= 0; m_per_h <= 0; m_snap_l <= 0; m_snap_h <= 0; m_rdata <= 0;
            m_cnt <= 0; m_run <= 0; m_to <= 0; m_ito <= 0; m_cont <= 0;
        end else begin
            if (m_run) begin
                if (m_cnt == 0) begin
                    m_to  <= 1'b1;
                    m_cnt <= {m_per_h, m_per_l};
                    if (!m_cont) m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (avm_chipselect && !avm_write_n) begin
                case (avm_address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ito  <= avm_writedata[0];
                        m_cont <= avm_writedata[1];
                        if (avm_writedata[2]) begin
                            m_run <= 1'b1;
                            m_cnt <= {m_per_h, m_per_l};
                        end
                        if (avm_writedata[3]) m_run <= 1'b0;
                    end
                    3'd2: m_per_l <= avm_writedata;
                    3'd3: m_per_h <= avm_writedata;
                    3'd4, 3'd5: {m_snap_h, m_snap_l} <= m_cnt;
                    default: ;
                endcase
            end
            if (avm_chipselect && avm_write_n) begin
                case (avm_address)
                    3'd0:    m_rdata <= {14'd0, m_run, m_to};
                    3'd2:    m_rdata <= m_per_l;
                    3'd3:    m_rdata <= m_per_h;
                    3'd4:    m_rdata <= m_snap_l;
                    3'd5:    m_rdata <= m_snap_h;
                    default: m_rdata <= 16'h0000;
                endcase
            end
        end
    end

    task automatic send_cmd(input logic [31:0] load, input logic cont);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = load; cmd_continuous = cont;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic stop_timer();
        bit ok = 0;
        @(negedge clk); stop_req = 1'b1;
        @(negedge clk); stop_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_ready === 1'b1 && running === 1'b0) begin ok = 1; break; end
            @(negedge clk);
        end
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stop_to_idle: cmd_ready=%b running=%b, expected 1/0 within 10 cycles", cmd_ready, running);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_assert++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        n_assert++;
        if ({tick, snap_valid, cmd_err, running} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {tick, snap_valid, cmd_err, running});
        end
        n_assert++;
        if (tick_count !== 16'd0 || snap_value !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: tick_count=%h snap_value=%h expected 0", tick_count, snap_value);
        end
        n_assert++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_bus: cs=%b wn=%b a=%0d d=%h expected 0 1 0 0000",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_sequence();
        logic [2:0]  ea [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
        logic [15:0] ed [5] = '{16'h0008, 16'h270F, 16'h0000, 16'h0000, 16'h0007};
        send_cmd(32'h0000_270F, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_assert++;
            if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== ea[i] || avm_writedata !== ed[i]) begin
                n_fail++;
                $display("FAIL start_write_%0d: cs=%b wn=%b a=%0d d=%h expected 1 0 %0d %h",
                         i, avm_chipselect, avm_write_n, avm_address, avm_writedata, ea[i], ed[i]);
            end
            if (i == 4) begin
                n_assert++;
                if (running !== 1'b0 || cmd_ready !== 1'b0) begin
                    n_fail++; $display("FAIL running_early: running=%b cmd_ready=%b expected 0 0", running, cmd_ready);
                end
            end
            @(negedge clk);
        end
        n_assert++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL running_set: got %b expected 1", running); end
    endtask

    // Continues from the first cycle after the control write (cycle 1).
    task automatic test_continuous_ticks();
        int cyc = 1;
        int ticks = 0;
        int first = -1;
        bit prev_clr = 0;
        while (cyc < 30010) begin
            if (tick === 1'b1) begin
                ticks++;
                if (first < 0) first = cyc;
                n_assert++;
                if (!prev_clr) begin n_fail++; $display("FAIL tick_after_clr: tick %0d at cycle %0d not preceded by write (0,0000)", ticks, cyc); end
            end
            prev_clr = (avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_address === 3'd0 && avm_writedata === 16'h0000);
            @(negedge clk);
            cyc++;
        end
        n_assert++;
        if (first < 10000 || first > 10006) begin n_fail++; $display("FAIL first_tick_time: got cycle %0d expected 10000..10006", first); end
        n_assert++;
        if (tick_count !== 16'd3 || ticks != 3) begin
            n_fail++; $display("FAIL tick_count_30000: tick_count=%0d pulses=%0d expected 3", tick_count, ticks);
        end
    endtask

    task automatic test_one_shot();
        logic [15:0] ctrl_seen = 16'hxxxx;
        logic prev_irq = 1'b0;
        bit edge_seen = 0;
        bit idle_ok = 0;
        int ticks = 0;
        send_cmd(32'd9, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (tick === 1'b1) ticks++;
            if (avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_address === 3'd1 && avm_writedata !== 16'h0008)
                ctrl_seen = avm_writedata;
            if (irq === 1'b1 && prev_irq === 1'b0) begin edge_seen = 1; break; end
            prev_irq = irq;
            @(negedge clk);
        end
        n_assert++;
        if (ctrl_seen !== 16'h0005) begin n_fail++; $display("FAIL oneshot_ctrl: got %h expected 0005", ctrl_seen); end
        n_assert++;
        if (!edge_seen) begin n_fail++; $display("FAIL oneshot_irq: no irq edge within 60 cycles, expected one"); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (tick === 1'b1) ticks++;
            if (running === 1'b0 && cmd_ready === 1'b1) idle_ok = 1;
        end
        n_assert++;
        if (!idle_ok) begin n_fail++; $display("FAIL oneshot_idle: running=%b cmd_ready=%b expected 0 1 within 3 cycles", running, cmd_ready); end
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (tick === 1'b1) ticks++;
        end
        n_assert++;
        if (ticks != 1 || tick_count !== 16'd1) begin
            n_fail++; $display("FAIL oneshot_ticks: pulses=%0d tick_count=%0d expected 1", ticks, tick_count);
        end
    endtask

    task automatic test_zero_load();
        bit cs_seen = 0;
        int errs = 0;
        send_cmd(32'd0, 1'b1);
        n_assert++;
        if (cmd_err !== 1'b1 || tick_count !== 16'd0 || avm_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_load: cmd_err=%b tick_count=%0d cs=%b expected 1 0 0", cmd_err, tick_count, avm_chipselect);
        end
        snap_req = 1'b1; stop_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0; stop_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (avm_chipselect !== 1'b0 || snap_valid !== 1'b0) cs_seen = 1;
            if (cmd_err === 1'b1) errs++;
            @(negedge clk);
        end
        n_assert++;
        if (cs_seen || errs != 0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_quiet: traffic=%0d extra_err=%0d cmd_ready=%b expected 0 0 1", cs_seen, errs, cmd_ready);
        end
    endtask

    task automatic test_snapshot();
        logic        acc_w [3];
        logic [2:0]  acc_a [3];
        logic [15:0] acc_d [3];
        logic [31:0] got = 32'hxxxx_xxxx;
        int n_acc = 0;
        int n_valid = 0;
        bit found = 0;
        send_cmd(32'h0001_0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_address === 3'd1 && avm_writedata[2] === 1'b1) begin
                found = 1; break;
            end
            @(negedge clk);
        end
        n_assert++;
        if (!found) begin n_fail++; $display("FAIL snap_start: control write not seen, expected within 10 cycles"); end
        repeat (100) @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (avm_chipselect === 1'b1 && n_acc < 3) begin
                acc_w[n_acc] = !avm_write_n; acc_a[n_acc] = avm_address; acc_d[n_acc] = avm_writedata; n_acc++;
            end
            if (snap_valid === 1'b1) begin n_valid++; got = snap_value; end
            @(negedge clk);
        end
        n_assert++;
        if (n_acc != 3 || acc_w[0] !== 1'b1 || acc_a[0] !== 3'd4 || acc_d[0] !== 16'h0000 ||
            acc_w[1] !== 1'b0 || acc_a[1] !== 3'd4 || acc_w[2] !== 1'b0 || acc_a[2] !== 3'd5) begin
            n_fail++;
            $display("FAIL snap_bus: %0d accesses w/a = %b/%0d %b/%0d %b/%0d expected 1/4 0/4 0/5",
                     n_acc, acc_w[0], acc_a[0], acc_w[1], acc_a[1], acc_w[2], acc_a[2]);
        end
        n_assert++;
        if (n_valid != 1 || got !== {m_snap_h, m_snap_l}) begin
            n_fail++; $display("FAIL snap_value: pulses=%0d got %h expected one pulse with %h", n_valid, got, {m_snap_h, m_snap_l});
        end
        n_assert++;
        if (!(got >= 32'h0000_FF99 && got <= 32'h0000_FF9D)) begin
            n_fail++; $display("FAIL snap_window: got %h expected 0000FF9B +/-2", got);
        end
        stop_timer();
    endtask

    task automatic test_stop_vs_irq();
        bit run_ok = 0;
        int ticks = 0;
        use_model_irq = 1'b0;
        irq_man = 1'b0;
        send_cmd(32'd1000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (running === 1'b1) begin run_ok = 1; break; end
            @(negedge clk);
        end
        n_assert++;
        if (!run_ok) begin n_fail++; $display("FAIL stop_irq_start: running=%b expected 1 within 10 cycles", running); end
        repeat (5) @(negedge clk);
        irq_man = 1'b1; stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        n_assert++;
        if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 3'd1 ||
            avm_writedata !== 16'h0008 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_write: cs=%b wn=%b a=%0d d=%h running=%b expected 1 0 1 0008 0",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata, running);
        end
        for (int i = 0; i < 6; i++) begin
            if (tick === 1'b1) ticks++;
            @(negedge clk);
        end
        n_assert++;
        if (ticks != 0 || tick_count !== 16'd0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_beats_irq: pulses=%0d tick_count=%0d cmd_ready=%b expected 0 0 1", ticks, tick_count, cmd_ready);
        end
        irq_man = 1'b0;
        use_model_irq = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start_sequence();
        test_continuous_ticks();
        stop_timer();
        test_one_shot();
        test_zero_load();
        test_snapshot();
        test_stop_vs_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_cfg_master.md
Name: timer_cfg_master

Overview:
- Avalon-MM initiator that drives the interval-timer slave (16-bit data, 3-bit word address, no waitrequest, registered 1-cycle read data).
- Converts a simple command handshake into the register-write sequence that programs, starts, stops and snapshots the timer.
- Services timeouts and reports them as tick pulses.
- Sits between a local control FSM (or CPU-less datapath) and the timer's s1 port.

Parameters:
- TICK_CNT_W, 16, width of the timeout counter output.
- POLL_INTERVAL, 64, clocks between status polls (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  start request.
- cmd_ready  out  1  high only in IDLE.
- cmd_load  in  32  counter load value; period = cmd_load+1 clocks.
- cmd_continuous  in  1  selects continuous (1) or one-shot (0) mode.
- stop_req  in  1  pulse; aborts a running timer.
- snap_req  in  1  pulse; captures the live counter.
- snap_value  out  32  captured counter value.
- snap_valid  out  1  1-cycle pulse.
- tick  out  1  1-cycle pulse per serviced timeout.
- tick_count  out  TICK_CNT_W  timeouts serviced since last accepted command; wraps.
- running  out  1  high from the start write until stop or one-shot completion.
- cmd_err  out  1  1-cycle pulse when a command is rejected.
- avm_address  out  3  slave word address.
- avm_chipselect  out  1  slave select.
- avm_write_n  out  1  active-low write.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  slave read data.
- irq  in  1  slave interrupt.

Behaviour:
- Bus timing:
  - All avm_* outputs are registered.
  - One access per clock; chipselect is held high for exactly one cycle per access.
  - A read is chipselect=1, write_n=1. Its data is sampled on the clock edge ending the following cycle.
  - Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
- Reset values: cmd_ready=1, all pulse outputs=0, running=0, tick_count=0, snap_value=0, bus idle, FSM in IDLE.
- FSM states and transitions:
  - IDLE -> W_STOP on cmd_valid with cmd_load!=0.
  - IDLE, cmd_valid with cmd_load==0: accept, pulse cmd_err, stay in IDLE, no bus traffic.
  - Start sequence, one cycle each: W_STOP (addr1, 0x0008) -> W_PL (addr2, cmd_load[15:0]) -> W_PH (addr3, cmd_load[31:16]) -> W_CLR (addr0, 0x0000) -> W_CTRL (addr1, {12'b0, 0,1,cont,ito}) -> RUN.
  - cmd_load and cmd_continuous are latched at acceptance. tick_count is cleared at acceptance.
  - running is set in the cycle after W_CTRL is issued.
- RUN priority, evaluated per cycle: stop_req > timeout > snap.
  - stop_req -> ABORT: write addr1, 0x0008 -> IDLE. running is cleared.
  - Timeout detection is on the rising edge of irq (registered previous value).
  - Timeout -> T_CLR: write addr0, 0x0000. Then tick pulses and tick_count increments.
  - After T_CLR: if one-shot, running is cleared and the FSM goes to IDLE; otherwise it returns to RUN.
  - snap -> S_W (write addr4, 0x0000) -> S_RL (read addr4) -> S_RH (read addr5) -> S_CAP. snap_value={hi,lo}; snap_valid pulses one cycle after S_CAP; then back to RUN.
- Pending flags:
  - snap_req and a timeout arriving while a sequence is in flight are held in sticky pending flags and serviced in priority order on return to RUN.
  - stop_req arriving mid-sequence is held pending. It is taken on return to RUN, after the current sequence completes.
  - snap_req in IDLE: ignored.
  - stop_req in IDLE: ignored.
  - Pending flags are cleared on entering IDLE.
- Width rules: tick_count wraps modulo 2^TICK_CNT_W.
- Reset mid-sequence: bus returns to idle immediately. The slave is not cleaned up; the next command's W_STOP handles that.

Optional Feature:
- Macro: TIMER_CFG_MASTER_POLL_EN.
- Defined:
  - irq is ignored; ito=0 is written in W_CTRL.
  - In RUN, status (addr0) is read every POLL_INTERVAL clocks.
  - Read data bit0=1 is treated as a timeout.
  - The poll read is lower priority than stop/timeout/snap. The poll counter restarts on entering RUN.
- Undefined: irq edge detection is used; ito=1 is written in W_CTRL.

Decomposition:
- Package timer_cfg_pkg:
  - FSM state enum.
  - Register address constants: STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5.
  - Control bit positions: ITO=0, CONT=1, START=2, STOP=3.
- Sub-module avm_single_access: registers one write/read per cycle and aligns read-data capture with a 1-cycle latency. The main FSM instantiates it once.

Test Plan:
- Reset, then cmd_load=0x0000_270F, continuous=1 -> bus writes (1,0x0008),(2,0x270F),(3,0x0000),(0,0x0000),(1,0x0007) on consecutive cycles; running=1 next cycle.
- Same setup with a slave model -> first tick 10000 clocks after start; tick_count=3 after 30000 clocks; each tick is preceded by a write (0,0x0000).
- One-shot, cmd_load=9 -> exactly one tick; running=0 and cmd_ready=1 within 3 cycles after the irq edge.
- snap_req at 100 cycles after start, cmd_load=0x0001_0000 -> write addr4, reads addr4 then addr5; snap_valid with snap_value = model counter at the snapshot write (0x0000_FF9B ±2).
- stop_req and irq rising edge in the same cycle -> ABORT write (1,0x0008), no tick, running=0.
- cmd_load=0 -> cmd_err pulse, no chipselect asserted, tick_count=0.
